// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair: channel count and
// receiver FSM state encoding.
package tdm_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    // Receiver states: waiting for a channel-a word, or collecting b..d.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects four time-multiplexed channel words into
// shadow slots and publishes them together when the channel-d word lands.
// Outputs only change on a complete frame; a new frame_start mid-frame
// aborts the partial frame and reports it with frame_err.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int NCH_P = NCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [SEL_W-1:0] sel,
    output logic             frame_valid,
    output logic             frame_err
);

    tdm_state_e       state_r;
    tdm_state_e       next_state_s;
    logic [SEL_W-1:0] next_sel_s;
    logic [WIDTH-1:0] slot0_r;
    logic [WIDTH-1:0] slot1_r;
    logic [WIDTH-1:0] slot2_r;
    logic             slot_we_s;
    logic [SEL_W-1:0] slot_idx_s;
    logic             load_s;
    logic             abort_s;

    // Next-state, slot-write and pulse decode; stalls (din_valid=0) hold everything.
    always_comb begin
        next_state_s = state_r;
        next_sel_s   = sel;
        slot_we_s    = 1'b0;
        slot_idx_s   = 2'd0;
        load_s       = 1'b0;
        abort_s      = 1'b0;
        if (din_valid) begin
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        slot_we_s    = 1'b1;
                        slot_idx_s   = 2'd0;
                        next_sel_s   = 2'd1;
                        next_state_s = RECV;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RECV: begin
                    if (frame_start) begin
                        // Restart: the new word becomes channel a of a fresh frame.
                        abort_s      = 1'b1;
                        slot_we_s    = 1'b1;
                        slot_idx_s   = 2'd0;
                        next_sel_s   = 2'd1;
                        next_state_s = RECV;
                    end else if (sel == 2'd3) begin
                        // Channel d goes straight to the output, not via a slot.
                        load_s       = 1'b1;
                        next_sel_s   = 2'd0;
                        next_state_s = IDLE;
                    end else begin
                        slot_we_s    = 1'b1;
                        slot_idx_s   = sel;
                        next_sel_s   = sel + 2'd1;
                        next_state_s = RECV;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_sel_s   = 2'd0;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // FSM state and channel index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sel     <= 2'd0;
        end else begin
            state_r <= next_state_s;
            sel     <= next_sel_s;
        end
    end

    // Shadow slots for channels a..c of the frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_r <= {WIDTH{1'b0}};
            slot1_r <= {WIDTH{1'b0}};
            slot2_r <= {WIDTH{1'b0}};
        end else if (slot_we_s) begin
            case (slot_idx_s)
                2'd0:    slot0_r <= din;
                2'd1:    slot1_r <= din;
                2'd2:    slot2_r <= din;
                default: slot0_r <= slot0_r;
            endcase
        end
    end

    // Published channel words, updated only when a whole frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= {WIDTH{1'b0}};
            b <= {WIDTH{1'b0}};
            c <= {WIDTH{1'b0}};
            d <= {WIDTH{1'b0}};
        end else if (load_s) begin
            a <= slot0_r;
            b <= slot1_r;
            c <= slot2_r;
            d <= din;
        end
    end

    // One-cycle status pulses; load and abort are mutually exclusive by decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= load_s;
            frame_err   <= abort_s;
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with a frame-level reference model.
module tb_tdm_demux;

    logic       clk;
    logic       rst;
    logic [1:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [1:0] a, b, c, d;
    logic [1:0] sel;
    logic       frame_valid;
    logic       frame_err;

    tdm_demux #(.WIDTH(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .a(a), .b(b), .c(c), .d(d),
        .sel(sel), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -1;
    int prev_pulse = -1;

    // Model: list of words in the frame being collected and last published frame.
    logic [1:0] part [4];
    int         part_n;
    logic [1:0] exp_a, exp_b, exp_c, exp_d;
    logic       exp_valid, exp_err;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        part_n = 0;
        exp_a = 2'd0; exp_b = 2'd0; exp_c = 2'd0; exp_d = 2'd0;
        exp_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_update(input logic [1:0] w, input logic v, input logic fs);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (v) begin
            if (fs) begin
                if (part_n > 0) exp_err = 1'b1;
                part[0] = w;
                part_n  = 1;
            end else if (part_n > 0) begin
                part[part_n] = w;
                part_n++;
                if (part_n == 4) begin
                    exp_a = part[0]; exp_b = part[1]; exp_c = part[2]; exp_d = part[3];
                    exp_valid = 1'b1;
                    part_n = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a", {6'd0, a}, {6'd0, exp_a});
        chk("b", {6'd0, b}, {6'd0, exp_b});
        chk("c", {6'd0, c}, {6'd0, exp_c});
        chk("d", {6'd0, d}, {6'd0, exp_d});
        chk("sel", {6'd0, sel}, 8'(part_n));
        chk("frame_valid", {7'd0, frame_valid}, {7'd0, exp_valid});
        chk("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
        chk("valid_err_excl", {7'd0, frame_valid & frame_err}, 8'd0);
        if (frame_valid) begin
            pulses++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    endtask

    // Drive one cycle at the falling edge, let the edge accept it, check at the next fall.
    task automatic step(input logic [1:0] w, input logic v, input logic fs);
        din = w; din_valid = v; frame_start = fs;
        @(posedge clk);
        model_update(w, v, fs);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0; frame_start = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 2'd0; din_valid = 1'b0; frame_start = 1'b0;
        model_reset();
        @(negedge clk);

        // Basic frame 00,10,01,11
        do_reset();
        step(2'b00, 1'b1, 1'b1); chk("lit_sel1", {6'd0, sel}, 8'd1);
        step(2'b10, 1'b1, 1'b0); chk("lit_sel2", {6'd0, sel}, 8'd2);
        step(2'b01, 1'b1, 1'b0); chk("lit_sel3", {6'd0, sel}, 8'd3);
        chk("lit_no_valid_early", {7'd0, frame_valid}, 8'd0);
        step(2'b11, 1'b1, 1'b0); chk("lit_sel0", {6'd0, sel}, 8'd0);
        chk("lit_valid", {7'd0, frame_valid}, 8'd1);
        chk("lit_a", {6'd0, a}, 8'h00);
        chk("lit_b", {6'd0, b}, 8'h02);
        chk("lit_c", {6'd0, c}, 8'h01);
        chk("lit_d", {6'd0, d}, 8'h03);
        step(2'b00, 1'b0, 1'b0);
        chk("lit_valid_one_cycle", {7'd0, frame_valid}, 8'd0);
        chk("lit_pulses_s1", 8'(pulses), 8'd1);

        // Same frame with a 3-cycle stall between b and c
        pulses = 0;
        step(2'b00, 1'b1, 1'b1);
        step(2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b0, (i == 1) ? 1'b1 : 1'b0);
            chk("lit_stall_sel", {6'd0, sel}, 8'd2);
        end
        step(2'b01, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("lit_pulses_s2", 8'(pulses), 8'd1);
        chk("lit_s2_c", {6'd0, c}, 8'h01);

        // Abort: 11,11 then a new frame 01,00,10,11
        pulses = 0;
        step(2'b11, 1'b1, 1'b1);
        step(2'b11, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        chk("lit_abort_err", {7'd0, frame_err}, 8'd1);
        chk("lit_abort_sel", {6'd0, sel}, 8'd1);
        chk("lit_abort_a_held", {6'd0, a}, 8'h00);
        step(2'b00, 1'b1, 1'b0);
        chk("lit_err_one_cycle", {7'd0, frame_err}, 8'd0);
        step(2'b10, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        chk("lit_s3_a", {6'd0, a}, 8'h01);
        chk("lit_s3_b", {6'd0, b}, 8'h00);
        chk("lit_s3_c", {6'd0, c}, 8'h02);
        chk("lit_s3_d", {6'd0, d}, 8'h03);
        chk("lit_pulses_s3", 8'(pulses), 8'd1);

        // Back-to-back frames
        pulses = 0;
        step(2'b00, 1'b1, 1'b1); step(2'b01, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b0); step(2'b11, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b1); step(2'b10, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0); step(2'b00, 1'b1, 1'b0);
        chk("lit_b2b_pulses", 8'(pulses), 8'd2);
        chk("lit_b2b_gap", 8'(last_pulse - prev_pulse), 8'd4);
        chk("lit_b2b_a", {6'd0, a}, 8'h03);
        chk("lit_b2b_d", {6'd0, d}, 8'h00);

        // Reset mid-frame, then a stray word, then a fresh frame
        step(2'b10, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        do_reset();
        chk("lit_rst_a", {6'd0, a}, 8'h00);
        chk("lit_rst_sel", {6'd0, sel}, 8'd0);
        step(2'b01, 1'b1, 1'b0);
        chk("lit_stray_sel", {6'd0, sel}, 8'd0);
        pulses = 0;
        step(2'b10, 1'b1, 1'b1); step(2'b11, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0); step(2'b01, 1'b1, 1'b0);
        chk("lit_s5_a", {6'd0, a}, 8'h02);
        chk("lit_s5_d", {6'd0, d}, 8'h01);
        chk("lit_pulses_s5", 8'(pulses), 8'd1);

        // Idle words without frame_start change nothing
        pulses = 0;
        for (int i = 0; i < 5; i++) step(2'(i), 1'b1, 1'b0);
        chk("lit_idle_pulses", 8'(pulses), 8'd0);
        chk("lit_idle_sel", {6'd0, sel}, 8'd0);
        chk("lit_idle_b", {6'd0, b}, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
